// File: rtl/ext_int_ctrl.sv
// External interrupt controller: counts or follows an external request line and
// raises a registered interrupt to the CPU until software acknowledges it.
module ext_int_ctrl #(
   parameter logic [31:0] BASE = 32'h00007f20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_src,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        int_out
);

   typedef enum logic [1:0] {IDLE, ASSERT, WAIT_LOW} state_t;

   localparam logic [31:0] ACK_ADDR   = BASE;
   localparam logic [31:0] CTRL_ADDR  = BASE + 32'd4;
   localparam logic [31:0] COUNT_ADDR = BASE + 32'd8;
   localparam logic [31:0] TOTAL_ADDR = BASE + 32'd12;

   state_t      state_q, state_d;
   logic        en_q, en_d;
   logic        mode_q, mode_d;
   logic        ovf_q, ovf_d;
   logic        irq_dly_q, irq_dly_d;
   logic [7:0]  count_q, count_d;
   logic [15:0] total_q, total_d;
   logic        int_out_q, int_out_d;

   logic [31:0] word_addr;
   logic        sel_ack, sel_ctrl, sel_count, sel_total;
   logic        wr, ctrl_wr, ack, rise, cnt_inc, cnt_dec;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:2];

   always_comb begin
      word_addr = addr & 32'hfffffffc;
      sel_ack   = (word_addr == ACK_ADDR);
      sel_ctrl  = (word_addr == CTRL_ADDR);
      sel_count = (word_addr == COUNT_ADDR);
      sel_total = (word_addr == TOTAL_ADDR);
      hit       = sel_ack | sel_ctrl | sel_count | sel_total;

      rdata = 32'd0;
      if (sel_ctrl) begin
         rdata = {23'd0, ovf_q, 6'd0, mode_q, en_q};
      end else if (sel_count) begin
         rdata = {24'd0, count_q};
      end else if (sel_total) begin
         rdata = {16'd0, total_q};
      end
   end

   always_comb begin
      wr      = |byteen;
      ctrl_wr = wr & sel_ctrl & byteen[0];
      // A CTRL write in the same cycle swallows the acknowledge.
      ack     = wr & sel_ack & (state_q == ASSERT) & ~ctrl_wr;
      rise    = irq_src & ~irq_dly_q;
      cnt_inc = rise & ~mode_q;
      cnt_dec = ack & ~mode_q;

      irq_dly_d = irq_src;
      en_d      = ctrl_wr ? wdata[0] : en_q;
      mode_d    = ctrl_wr ? wdata[1] : mode_q;
      ovf_d     = ovf_q & ~ctrl_wr;
      count_d   = count_q;
      total_d   = total_q;

      if (cnt_inc && !cnt_dec) begin
         if (count_q == 8'hff) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + 8'd1;
         end
      end else if (cnt_dec && !cnt_inc) begin
         count_d = count_q - 8'd1;
      end

      if (ack) begin
         total_d = total_q + 16'd1;
      end

      state_d = state_q;
      if (ctrl_wr || !en_q) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (mode_q ? irq_src : (count_q != 8'd0)) begin
                  state_d = ASSERT;
               end
            end
            ASSERT: begin
               if (ack) begin
                  state_d = mode_q ? WAIT_LOW : IDLE;
               end
            end
            WAIT_LOW: begin
               if (!irq_src) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      int_out_d = (state_d == ASSERT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         en_q      <= 1'b1;
         mode_q    <= 1'b0;
         ovf_q     <= 1'b0;
         irq_dly_q <= 1'b0;
         count_q   <= 8'd0;
         total_q   <= 16'd0;
         int_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         ovf_q     <= ovf_d;
         irq_dly_q <= irq_dly_d;
         count_q   <= count_d;
         total_q   <= total_d;
         int_out_q <= int_out_d;
      end
   end

   assign int_out = int_out_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the controller.
module tb_ext_int_ctrl;

   localparam logic [31:0] BASE   = 32'h00007f20;
   localparam logic [31:0] A_ACK  = BASE;
   localparam logic [31:0] A_CTRL = BASE + 32'd4;
   localparam logic [31:0] A_CNT  = BASE + 32'd8;
   localparam logic [31:0] A_TOT  = BASE + 32'd12;

   localparam int PH_QUIET  = 0;
   localparam int PH_RAISED = 1;
   localparam int PH_HOLD   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        irq_src = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [3:0]  byteen = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic        hit;
   logic [31:0] rdata;
   logic        int_out;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Model state: pending edges, acknowledged total, control bits, interrupt phase.
   int m_pend  = 0;
   int m_tot   = 0;
   bit m_en    = 1'b1;
   bit m_mode  = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_prev  = 1'b0;
   int m_phase = PH_QUIET;

   ext_int_ctrl #(.BASE(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_src (irq_src),
      .addr    (addr),
      .byteen  (byteen),
      .wdata   (wdata),
      .hit     (hit),
      .rdata   (rdata),
      .int_out (int_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] wa;
      wa = a & 32'hfffffffc;
      if (wa == A_CTRL) return {23'd0, m_ovf, 6'd0, m_mode, m_en};
      if (wa == A_CNT)  return 32'(m_pend);
      if (wa == A_TOT)  return 32'(m_tot);
      return 32'd0;
   endfunction

   function automatic logic m_hit(input logic [31:0] a);
      logic [31:0] wa;
      wa = a & 32'hfffffffc;
      return (wa >= BASE) && (wa <= A_TOT);
   endfunction

   task automatic m_clock(input bit rst, input bit i, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] w);
      logic [31:0] wa;
      bit ctrl_w, ack, rise;
      int n, nxt;
      if (!rst) begin
         m_pend = 0; m_tot = 0; m_en = 1'b1; m_mode = 1'b0;
         m_ovf = 1'b0; m_prev = 1'b0; m_phase = PH_QUIET;
         return;
      end
      wa     = a & 32'hfffffffc;
      ctrl_w = (b != 4'd0) && (wa == A_CTRL) && b[0];
      ack    = (b != 4'd0) && (wa == A_ACK) && (m_phase == PH_RAISED) && !ctrl_w;
      rise   = i && !m_prev;
      if (ctrl_w || !m_en)            nxt = PH_QUIET;
      else if (m_phase == PH_QUIET)   nxt = (m_mode ? i : (m_pend > 0)) ? PH_RAISED : PH_QUIET;
      else if (m_phase == PH_RAISED)  nxt = !ack ? PH_RAISED : (m_mode ? PH_HOLD : PH_QUIET);
      else                            nxt = i ? PH_HOLD : PH_QUIET;
      if (ctrl_w) m_ovf = 1'b0;
      if (!m_mode) begin
         n = m_pend + (rise ? 1 : 0) - (ack ? 1 : 0);
         if (n > 255) begin
            n = 255;
            m_ovf = 1'b1;
         end
         m_pend = n;
      end
      if (ack) m_tot = (m_tot + 1) % 65536;
      if (ctrl_w) begin
         m_en   = w[0];
         m_mode = w[1];
      end
      m_prev  = i;
      m_phase = nxt;
   endtask

   task automatic step(input bit i, input logic [31:0] a, input logic [3:0] b, input logic [31:0] w);
      irq_src = i; addr = a; byteen = b; wdata = w;
      @(posedge clk);
      m_clock(reset, i, a, b, w);
      #1;
   endtask

   task automatic nop(input bit i);
      step(i, 32'd0, 4'd0, 32'd0);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a; byteen = 4'd0;
      #1;
      chk(name, rdata, exp);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      nop(1'b0);
      nop(1'b0);
      reset = 1'b1;
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("int_out", {31'd0, int_out}, {31'd0, m_phase == PH_RAISED});
         chk("hit", {31'd0, hit}, {31'd0, m_hit(addr)});
         chk("rdata", rdata, m_read(addr));
      end
   end

   initial begin
      bit got;
      bit irq_n;
      logic [31:0] a, w;
      logic [3:0] b;

      reset = 1'b0;
      nop(1'b0);
      check_en = 1'b1;
      nop(1'b0);
      reset = 1'b1;
      chk("rst_int_out", {31'd0, int_out}, 32'd0);
      rd_chk("rst_ctrl", A_CTRL, 32'h1);
      rd_chk("rst_count", A_CNT, 32'h0);
      rd_chk("rst_total", A_TOT, 32'h0);

      // Single pulse, edge mode.
      nop(1'b1);
      chk("p1_int_low", {31'd0, int_out}, 32'd0);
      rd_chk("p1_count", A_CNT, 32'h1);
      nop(1'b0);
      chk("p1_int_high", {31'd0, int_out}, 32'd1);
      step(1'b0, A_ACK, 4'h1, 32'd0);
      chk("p1_ack_low", {31'd0, int_out}, 32'd0);
      rd_chk("p1_count0", A_CNT, 32'h0);
      rd_chk("p1_total", A_TOT, 32'h1);

      // Three pulses, then three acknowledge rounds.
      apply_reset();
      repeat (3) begin
         nop(1'b1);
         nop(1'b0);
      end
      rd_chk("p3_count", A_CNT, 32'h3);
      for (int r = 0; r < 3; r++) begin
         got = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (!got) begin
               if (int_out) got = 1'b1;
               else nop(1'b0);
            end
         end
         chk("p3_assert", {31'd0, got}, 32'd1);
         step(1'b0, A_ACK, 4'h8, 32'd0);
         chk("p3_low_after_ack", {31'd0, int_out}, 32'd0);
      end
      rd_chk("p3_total", A_TOT, 32'h3);
      rd_chk("p3_count0", A_CNT, 32'h0);

      // Counter saturation and overflow flag.
      apply_reset();
      repeat (256) begin
         nop(1'b1);
         nop(1'b0);
      end
      rd_chk("ovf_count", A_CNT, 32'hff);
      rd_chk("ovf_ctrl", A_CTRL, 32'h101);
      step(1'b0, A_CTRL, 4'hf, 32'h1);
      chk("ovf_forced_idle", {31'd0, int_out}, 32'd0);
      rd_chk("ovf_ctrl_clr", A_CTRL, 32'h1);
      rd_chk("ovf_count_kept", A_CNT, 32'hff);
      nop(1'b0);
      chk("ovf_reassert", {31'd0, int_out}, 32'd1);

      // Level mode.
      apply_reset();
      step(1'b0, A_CTRL, 4'hf, 32'h3);
      nop(1'b1);
      chk("lvl_assert", {31'd0, int_out}, 32'd1);
      step(1'b1, A_ACK, 4'h1, 32'd0);
      chk("lvl_ack_low", {31'd0, int_out}, 32'd0);
      rd_chk("lvl_total", A_TOT, 32'h1);
      repeat (3) nop(1'b1);
      chk("lvl_wait_low", {31'd0, int_out}, 32'd0);
      rd_chk("lvl_count", A_CNT, 32'h0);
      nop(1'b0);
      chk("lvl_idle", {31'd0, int_out}, 32'd0);
      nop(1'b1);
      chk("lvl_reassert", {31'd0, int_out}, 32'd1);

      // Acknowledge coincident with a new rising edge.
      apply_reset();
      nop(1'b1);
      nop(1'b0);
      chk("co_assert", {31'd0, int_out}, 32'd1);
      step(1'b1, A_ACK, 4'h1, 32'd0);
      chk("co_low", {31'd0, int_out}, 32'd0);
      rd_chk("co_count", A_CNT, 32'h1);
      rd_chk("co_total", A_TOT, 32'h1);
      nop(1'b0);
      chk("co_reassert", {31'd0, int_out}, 32'd1);

      // Reset while asserted, with an ack and an edge in the reset cycle.
      apply_reset();
      nop(1'b1);
      nop(1'b0);
      nop(1'b1);
      chk("ra_assert", {31'd0, int_out}, 32'd1);
      rd_chk("ra_count2", A_CNT, 32'h2);
      reset = 1'b0;
      step(1'b0, A_ACK, 4'hf, 32'd0);
      reset = 1'b1;
      chk("ra_int_out", {31'd0, int_out}, 32'd0);
      rd_chk("ra_ctrl", A_CTRL, 32'h1);
      rd_chk("ra_count", A_CNT, 32'h0);
      rd_chk("ra_total", A_TOT, 32'h0);

      // Random traffic checked every cycle by the compare process.
      for (int c = 0; c < 4000; c++) begin
         irq_n = ($urandom_range(0, 9) < 3) ? ~irq_src : irq_src;
         case ($urandom_range(0, 4))
            0: a = A_ACK;
            1: a = A_CTRL;
            2: a = A_CNT;
            3: a = A_TOT;
            default: a = $urandom & 32'h0000ffff;
         endcase
         a = a | 32'($urandom_range(0, 3));
         b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         w = $urandom;
         if ($urandom_range(0, 3) != 0) w[0] = 1'b1;
         if ($urandom_range(0, 299) == 0) reset = 1'b0;
         step(irq_n, a, b, w);
         reset = 1'b1;
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_int_ctrl.md
EXT_INT_CTRL -- requirements
Module: ext_int_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 32'h00007f20, word address of the ACK register; CTRL = BASE+4, COUNT = BASE+8, TOTAL = BASE+12.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-004 SHALL have port irq_src  input  1  external request line, synchronous to clk.
REQ-005 SHALL have port addr  input  32  CPU data-side byte address.
REQ-006 SHALL have port byteen  input  4  CPU store byte enables; any bit set = write.
REQ-007 SHALL have port wdata  input  32  CPU store data.
REQ-008 SHALL have port hit  output  1  combinational; 1 when (addr & 32'hfffffffc) is BASE..BASE+12.
REQ-009 SHALL have port rdata  output  32  combinational read data for the addressed register; 0 when hit=0.
REQ-010 SHALL have port int_out  output  1  registered interrupt request to CPU.

Function
REQ-011 SHALL decode registers by (addr & 32'hfffffffc); low two address bits ignored.
REQ-012 SHALL define CTRL: bit0 EN, bit1 MODE (0 edge, 1 level), bit8 OVF (sticky), others read 0.
REQ-013 SHALL, on write to CTRL with byteen[0]=1, load EN/MODE from wdata[1:0], clear OVF, force state IDLE next cycle.
REQ-014 SHALL define COUNT as 8-bit pending-edge counter (read zero-extended); TOTAL as 16-bit acknowledged counter, wraps 16'hffff -> 0; both read-only, writes ignored.
REQ-015 SHALL register irq_src into irq_d each cycle; rising edge = irq_src & ~irq_d.
REQ-016 SHALL, in edge mode, increment COUNT on each rising edge; at 8'hff the edge is dropped and OVF set.
REQ-017 SHALL implement states IDLE, ASSERT, WAIT_LOW; int_out = 1 exactly when state is ASSERT.
REQ-018 SHALL transition IDLE -> ASSERT when EN=1 and (edge mode: COUNT != 0; level mode: irq_src = 1); int_out rises one cycle after the condition.
REQ-019 SHALL treat any write (|byteen) to ACK while in ASSERT as acknowledge; writes to ACK in other states ignored.
REQ-020 SHALL, on acknowledge in edge mode, decrement COUNT, increment TOTAL, go IDLE; int_out low for at least one cycle before re-asserting.
REQ-021 SHALL, on acknowledge in level mode, increment TOTAL and go WAIT_LOW; WAIT_LOW -> IDLE when irq_src = 0.
REQ-022 SHALL, on simultaneous rising edge and acknowledge in the same cycle, leave COUNT unchanged (net +1 -1), incl. at 8'hff (no OVF).
REQ-023 SHALL, when EN = 0 in any state, go IDLE next cycle with COUNT preserved; edges still counted while EN = 0.
REQ-024 SHALL give CTRL-write force-IDLE (REQ-013) priority over acknowledge in the same cycle; acknowledge then ignored.

Reset
REQ-025 SHALL, while reset = 0 at a rising edge, set state IDLE, int_out 0, EN 1, MODE 0, OVF 0, COUNT 0, TOTAL 0, irq_d 0.
REQ-026 SHALL abandon a reset during ASSERT with no acknowledge counted; int_out 0 the first cycle after the reset edge.
REQ-027 SHALL ignore irq_src edges and bus writes in the reset cycle.

Verification
REQ-028 SHALL cover: edge mode, single 1-cycle irq_src pulse -> COUNT 1, int_out 1 next cycle; sw 0 to 0x7f20 -> int_out 0, COUNT 0, TOTAL 1.
REQ-029 SHALL cover: 3 pulses before any ack -> three assert/ack rounds, int_out low >= 1 cycle between rounds, TOTAL 3.
REQ-030 SHALL cover: 256 pulses, no ack -> COUNT 8'hff, CTRL reads 32'h101; write CTRL 32'h1 -> reads 32'h1, COUNT still 8'hff.
REQ-031 SHALL cover: CTRL 32'h3 (level), irq_src held high, ack -> WAIT_LOW, int_out stays 0 until irq_src low then high again -> int_out 1.
REQ-032 SHALL cover: ack coincident with new rising edge at COUNT 1 -> COUNT 1, int_out re-asserts after one low cycle.
REQ-033 SHALL cover: reset = 0 during ASSERT with COUNT 2 -> all registers at REQ-025 values, TOTAL 0.
